// File: rtl/ysyx_220053_ifu_pfq.sv
// ysyx_220053_ifu_pfq -- instruction fetch unit with prefetch queue.
//
// Requests whole icache lines, unpacks every 32-bit word from the fetch PC to
// the end of the line into a circular queue, and hands one instruction per
// cycle to decode over a valid/ready handshake. A redirect flushes the queue
// and discards the response of any request still in flight.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   redirect_valid/redirect_pc    flush and restart fetch at redirect_pc
//   req_valid/req_addr/req_ready  line-aligned request to the icache
//   resp_valid/resp_data          line returned by the icache (1-cycle pulse)
//   inst_valid/inst/inst_pc       queue head towards decode
//   inst_ready                    decode consumes the head
//
// Optional macro IFU_PFQ_PERF_EN adds saturating 32-bit counters
//   perf_req_cnt, perf_drop_cnt, perf_stall_cnt.
module ysyx_220053_ifu_pfq #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000),
    parameter int                LINE_W   = 128,
    parameter int                QDEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              resp_valid,
    input  logic [LINE_W-1:0] resp_data,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
`ifdef IFU_PFQ_PERF_EN
    output logic [31:0]       perf_req_cnt,
    output logic [31:0]       perf_drop_cnt,
    output logic [31:0]       perf_stall_cnt,
`endif
    input  logic              inst_ready
);

    localparam int W     = LINE_W / 32;
    localparam int LB    = LINE_W / 8;
    localparam int OFF_W = (W > 1) ? $clog2(W) : 1;
    localparam int QA_W  = $clog2(QDEPTH);
    localparam int PTR_W = QA_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_drop;
    logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
    logic [31:0]       r_q_inst [QDEPTH];
    logic [ADDR_W-1:0] r_q_pc   [QDEPTH];

    logic [OFF_W:0]    w_off;
    logic [31:0]       w_need, w_free;
    logic [PTR_W-1:0]  w_count;
    logic              w_empty, w_pop, w_push;
    logic              w_req_fire, w_drop_resp, w_stall;
    logic [ADDR_W-1:0] w_line_base, w_redir_pc;
    logic [LINE_W-1:0] w_shift;
    logic              w_unused;

    // Word index of the fetch PC inside its line.
    generate
        if (W > 1) begin : g_off
            assign w_off = {1'b0, r_fetch_pc[OFF_W+1:2]};
        end else begin : g_off1
            assign w_off = '0;
        end
    endgenerate

    assign w_unused    = ^redirect_pc[1:0];
    assign w_redir_pc  = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_line_base = r_fetch_pc & ~ADDR_W'(LB - 1);
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_pop       = ~w_empty & inst_ready;
    // Space seen by the fetch decision counts a pop happening this cycle.
    assign w_free      = 32'(QDEPTH) - 32'(w_count) + 32'(w_pop);
    assign w_need      = 32'(W) - 32'(w_off);
    assign w_push      = (r_state == S_WAIT) & resp_valid & ~redirect_valid;
    // Word at the fetch PC lands in slot 0 after this shift.
    assign w_shift     = resp_data >> (32 * w_off);

    assign req_valid  = (r_state == S_REQ);
    assign req_addr   = r_req_addr;
    assign inst_valid = ~w_empty;
    assign inst       = r_q_inst[r_rd_ptr[QA_W-1:0]];
    assign inst_pc    = r_q_pc[r_rd_ptr[QA_W-1:0]];

    always_comb begin
        w_state_nxt = r_state;
        w_req_fire  = 1'b0;
        w_drop_resp = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_free < w_need)      w_stall = 1'b1;
                else if (!redirect_valid) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                // A redirect seen while the request is pending poisons it.
                if (req_ready) begin
                    w_req_fire  = 1'b1;
                    w_state_nxt = (r_drop | redirect_valid) ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_valid) begin
                    w_state_nxt = S_IDLE;
                    w_drop_resp = redirect_valid;
                end else if (redirect_valid) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                // The one outstanding response retires here even if another
                // redirect arrives alongside it; otherwise fetch would wait
                // for a response that never comes.
                if (resp_valid) begin
                    w_state_nxt = S_IDLE;
                    w_drop_resp = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= '0;
            r_drop     <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_inst[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_state_nxt == S_REQ) r_req_addr <= w_line_base;

            if (r_state == S_REQ && redirect_valid)   r_drop <= 1'b1;
            else if (r_state == S_DROP && resp_valid) r_drop <= 1'b0;

            if (redirect_valid)  r_fetch_pc <= w_redir_pc;
            else if (w_push)     r_fetch_pc <= w_line_base + ADDR_W'(LB);

            if (redirect_valid) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_push) begin
                    for (int j = 0; j < W; j++) begin
                        if (unsigned'(j) < w_need) begin
                            r_q_inst[r_wr_ptr[QA_W-1:0] + QA_W'(j)] <= w_shift[32*j +: 32];
                            r_q_pc[r_wr_ptr[QA_W-1:0] + QA_W'(j)]   <= r_fetch_pc + ADDR_W'(4 * j);
                        end
                    end
                    r_wr_ptr <= r_wr_ptr + PTR_W'(w_need);
                end
            end
        end
    end

`ifdef IFU_PFQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_req_cnt   <= '0;
            perf_drop_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_req_fire  && perf_req_cnt   != '1) perf_req_cnt   <= perf_req_cnt + 1'b1;
            if (w_drop_resp && perf_drop_cnt  != '1) perf_drop_cnt  <= perf_drop_cnt + 1'b1;
            if (w_stall     && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif

endmodule
